alarm_mode_controller: RTL and testbench
========================================

ALARM_MODE_CONTROLLER -- requirements
Module: alarm_mode_controller

Interface
REQ-001 Parameter AUTO_SILENCE, default 1; 1 = ringing self-clears when the time no longer equals the alarm time.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  debounced single-cycle button pulses.
REQ-006 alarm_en  in  1  level switch; 1 arms the alarm.
REQ-007 t_hour_tens[2:0], t_hour_units[3:0], t_min_tens[2:0], t_min_units[3:0]  in  current BCD time from the system counter.
REQ-008 counter_enable  out  1  enables the running time counter.
REQ-009 time_inc, time_dec  out  1  single-cycle adjust pulses to the time counter.
REQ-010 time_sel  out  1  adjust target: 0 = minutes, 1 = hours.
REQ-011 a_hour_tens[2:0], a_hour_units[3:0], a_min_tens[2:0], a_min_units[3:0]  out  stored BCD alarm time.
REQ-012 disp_alarm  out  1  display mux select: 1 = show alarm digits.
REQ-013 mode_led[3:0]  out  one-hot adjust-state indicator, all zero in CLOCK.
REQ-014 ringing  out  1  alarm buzzer/LED drive.

Function
REQ-015 FSM states: CLOCK, SET_TH, SET_TM, SET_AH, SET_AM.
REQ-016 btn_c: CLOCK -> SET_TH; any SET_* state -> CLOCK.
REQ-017 btn_r cycles SET_TH -> SET_TM -> SET_AH -> SET_AM -> SET_TH; btn_l cycles in reverse; both are ignored in CLOCK.
REQ-018 Only one button acts per cycle, with priority c > l > r > u > d; lower-priority pulses in the same cycle are dropped.
REQ-019 counter_enable = 1 only in CLOCK; it is registered and changes in the cycle after the transition.
REQ-020 In SET_TH/SET_TM, btn_u/btn_d produce exactly one registered time_inc/time_dec pulse, one cycle after the button; time_sel = 1 in SET_TH and 0 in SET_TM.
REQ-021 In SET_AH/SET_AM, btn_u/btn_d adjust the alarm register in BCD.
REQ-022 Alarm hours wrap 23 -> 00 on up and 00 -> 23 on down.
REQ-023 Alarm minutes wrap 59 -> 00 and 00 -> 59; a minute wrap does not carry into hours.
REQ-024 btn_u/btn_d in CLOCK have no effect unless ringing is set.
REQ-025 disp_alarm = 1 in SET_AH/SET_AM, otherwise 0.
REQ-026 mode_led: bit 0 = SET_TH, bit 1 = SET_TM, bit 2 = SET_AH, bit 3 = SET_AM.
REQ-027 Match = registered equality of all four time digits with the alarm digits.
REQ-028 ringing sets on the rising edge of match while alarm_en = 1 and state = CLOCK.
REQ-029 While ringing = 1, any button pulse clears ringing and is consumed, causing no other action that cycle.
REQ-030 ringing also clears when alarm_en = 0, and, if AUTO_SILENCE = 1, when match falls.
REQ-031 Leaving CLOCK clears ringing.
REQ-032 Re-entering CLOCK while match is already true does not ring, because a match edge is required.

Reset
REQ-033 Reset returns the FSM to CLOCK.
REQ-034 Reset values: counter_enable = 1; time_inc = time_dec = time_sel = 0; disp_alarm = 0; mode_led = 0; ringing = 0.
REQ-035 Reset sets the alarm register to 00:00 and the match history to 0.
REQ-036 Reset asserted mid-adjust overrides any simultaneous button pulse.

Structure
REQ-037 Package alarm_pkg SHALL hold the state encoding and the BCD limits (HOUR_MAX = 23, MIN_MAX = 59).
REQ-038 One sub-module, bcd_wrap_adjust, SHALL perform BCD inc/dec with wrap for one hour or minute field; it is instantiated twice.

Verification
REQ-039 Reset, then btn_c -> the next cycle shows counter_enable = 0 and mode_led = 0001; btn_u -> time_inc = 1 for exactly one cycle with time_sel = 1.
REQ-040 SET_AH with alarm at 23:00, btn_u -> 00:00; SET_AM with 00:00, btn_d -> 00:59, hours unchanged.
REQ-041 btn_c and btn_u in the same cycle in SET_TM -> state = CLOCK and no time_inc pulse.
REQ-042 alarm_en = 1, alarm = 07:30, time steps 07:29 -> 07:30 -> ringing = 1 the next cycle; with AUTO_SILENCE = 1, time 07:31 -> ringing = 0.
REQ-043 While ringing, btn_u -> ringing = 0, no time_inc, state stays CLOCK.
REQ-044 Reset asserted in SET_AM while btn_u pulses -> CLOCK, alarm = 00:00, counter_enable = 1.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding, BCD field limits and the mode indicator decode for the
// alarm clock mode controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        StClock,
        StSetTh,
        StSetTm,
        StSetAh,
        StSetAm
    } state_e;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    function automatic logic [3:0] mode_led_of(state_e s);
        logic [3:0] led;
        case (s)
            StSetTh: led = 4'b0001;
            StSetTm: led = 4'b0010;
            StSetAh: led = 4'b0100;
            StSetAm: led = 4'b1000;
            default: led = 4'b0000;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/bcd_wrap_adjust.sv
// Two-digit BCD increment/decrement with wrap between 00 and MAX. Purely
// combinational; with no request the field passes through unchanged.
module bcd_wrap_adjust #(
    parameter int unsigned MAX = 59
) (
    input  logic       inc,
    input  logic       dec,
    input  logic [2:0] tens,
    input  logic [3:0] units,
    output logic [2:0] next_tens,
    output logic [3:0] next_units
);

    localparam logic [2:0] MaxTens  = 3'(MAX / 10);
    localparam logic [3:0] MaxUnits = 4'(MAX % 10);

    always_comb begin
        next_tens  = tens;
        next_units = units;
        if (inc) begin
            if (tens == MaxTens && units == MaxUnits) begin
                next_tens  = 3'd0;
                next_units = 4'd0;
            end else if (units == 4'd9) begin
                next_tens  = tens + 3'd1;
                next_units = 4'd0;
            end else begin
                next_units = units + 4'd1;
            end
        end else if (dec) begin
            if (tens == 3'd0 && units == 4'd0) begin
                next_tens  = MaxTens;
                next_units = MaxUnits;
            end else if (units == 4'd0) begin
                next_tens  = tens - 3'd1;
                next_units = 4'd9;
            end else begin
                next_units = units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_mode_controller.sv
// Button-driven mode FSM for a clock with one alarm: time adjust pulses, BCD
// alarm register, and match-edge triggered ringing.
module alarm_mode_controller
    import alarm_pkg::*;
#(
    parameter bit AUTO_SILENCE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_en,
    input  logic [2:0] t_hour_tens,
    input  logic [3:0] t_hour_units,
    input  logic [2:0] t_min_tens,
    input  logic [3:0] t_min_units,
    output logic       counter_enable,
    output logic       time_inc,
    output logic       time_dec,
    output logic       time_sel,
    output logic [2:0] a_hour_tens,
    output logic [3:0] a_hour_units,
    output logic [2:0] a_min_tens,
    output logic [3:0] a_min_units,
    output logic       disp_alarm,
    output logic [3:0] mode_led,
    output logic       ringing
);

    state_e     state, state_next;
    logic       consume, inc_req, dec_req;
    logic       match_now, match_q, ring_next;
    logic [2:0] hour_tens_next, min_tens_next;
    logic [3:0] hour_units_next, min_units_next;

    assign match_now = {t_hour_tens, t_hour_units, t_min_tens, t_min_units} ==
                       {a_hour_tens, a_hour_units, a_min_tens, a_min_units};

    // Single-button decode, priority c > l > r > u > d; a press while ringing
    // only silences the buzzer.
    always_comb begin
        state_next = state;
        inc_req    = 1'b0;
        dec_req    = 1'b0;
        consume    = ringing && (btn_c || btn_l || btn_r || btn_u || btn_d);
        if (!consume) begin
            if (btn_c) begin
                state_next = (state == StClock) ? StSetTh : StClock;
            end else if (btn_l) begin
                case (state)
                    StSetTh: state_next = StSetAm;
                    StSetTm: state_next = StSetTh;
                    StSetAh: state_next = StSetTm;
                    StSetAm: state_next = StSetAh;
                    default: state_next = state;
                endcase
            end else if (btn_r) begin
                case (state)
                    StSetTh: state_next = StSetTm;
                    StSetTm: state_next = StSetAh;
                    StSetAh: state_next = StSetAm;
                    StSetAm: state_next = StSetTh;
                    default: state_next = state;
                endcase
            end else if (btn_u) begin
                inc_req = 1'b1;
            end else if (btn_d) begin
                dec_req = 1'b1;
            end
        end
    end

    always_comb begin
        ring_next = ringing;
        if (consume || state_next != StClock || !alarm_en) begin
            ring_next = 1'b0;
        end else if (AUTO_SILENCE && !match_now) begin
            ring_next = 1'b0;
        end else if (state == StClock && match_now && !match_q) begin
            ring_next = 1'b1;
        end
    end

    bcd_wrap_adjust #(
        .MAX (HOUR_MAX)
    ) u_hour_adj (
        .inc        (inc_req && state == StSetAh),
        .dec        (dec_req && state == StSetAh),
        .tens       (a_hour_tens),
        .units      (a_hour_units),
        .next_tens  (hour_tens_next),
        .next_units (hour_units_next)
    );

    bcd_wrap_adjust #(
        .MAX (MIN_MAX)
    ) u_min_adj (
        .inc        (inc_req && state == StSetAm),
        .dec        (dec_req && state == StSetAm),
        .tens       (a_min_tens),
        .units      (a_min_units),
        .next_tens  (min_tens_next),
        .next_units (min_units_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StClock;
            counter_enable <= 1'b1;
            time_inc       <= 1'b0;
            time_dec       <= 1'b0;
            time_sel       <= 1'b0;
            disp_alarm     <= 1'b0;
            mode_led       <= 4'b0000;
            ringing        <= 1'b0;
            match_q        <= 1'b0;
            a_hour_tens    <= 3'd0;
            a_hour_units   <= 4'd0;
            a_min_tens     <= 3'd0;
            a_min_units    <= 4'd0;
        end else begin
            state          <= state_next;
            counter_enable <= (state_next == StClock);
            time_inc       <= inc_req && (state == StSetTh || state == StSetTm);
            time_dec       <= dec_req && (state == StSetTh || state == StSetTm);
            time_sel       <= (state_next == StSetTh);
            disp_alarm     <= (state_next == StSetAh || state_next == StSetAm);
            mode_led       <= mode_led_of(state_next);
            ringing        <= ring_next;
            match_q        <= match_now;
            a_hour_tens    <= hour_tens_next;
            a_hour_units   <= hour_units_next;
            a_min_tens     <= min_tens_next;
            a_min_units    <= min_units_next;
        end
    end

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Self-checking bench for alarm_mode_controller: expected output snapshots are
// queued as each stimulus is driven and compared once the DUT has clocked it.
module tb_alarm_mode_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_c, btn_l, btn_r, btn_u, btn_d;
    logic       alarm_en;
    logic [2:0] t_hour_tens, t_min_tens;
    logic [3:0] t_hour_units, t_min_units;
    logic       counter_enable, time_inc, time_dec, time_sel, disp_alarm, ringing;
    logic [2:0] a_hour_tens, a_min_tens;
    logic [3:0] a_hour_units, a_min_units, mode_led;

    alarm_mode_controller #(
        .AUTO_SILENCE (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_c          (btn_c),
        .btn_l          (btn_l),
        .btn_r          (btn_r),
        .btn_u          (btn_u),
        .btn_d          (btn_d),
        .alarm_en       (alarm_en),
        .t_hour_tens    (t_hour_tens),
        .t_hour_units   (t_hour_units),
        .t_min_tens     (t_min_tens),
        .t_min_units    (t_min_units),
        .counter_enable (counter_enable),
        .time_inc       (time_inc),
        .time_dec       (time_dec),
        .time_sel       (time_sel),
        .a_hour_tens    (a_hour_tens),
        .a_hour_units   (a_hour_units),
        .a_min_tens     (a_min_tens),
        .a_min_units    (a_min_units),
        .disp_alarm     (disp_alarm),
        .mode_led       (mode_led),
        .ringing        (ringing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ce;
        logic        inc;
        logic        dec;
        logic        sel;
        logic        disp;
        logic [3:0]  led;
        logic        ring;
        logic [13:0] alarm;
    } obs_t;

    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BL = 5'b01000;
    localparam logic [4:0] BR = 5'b00100;
    localparam logic [4:0] BU = 5'b00010;
    localparam logic [4:0] BD = 5'b00001;
    localparam logic [4:0] BN = 5'b00000;

    localparam int SC = 0;
    localparam int TH = 1;
    localparam int TM = 2;
    localparam int AH = 3;
    localparam int AM = 4;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ah = 0;
    int   am = 0;

    function automatic obs_t mk(bit ce, bit inc, bit dec, bit sel, bit disp,
                                logic [3:0] led, bit ring, int h, int m);
        obs_t o;
        o.ce    = ce;
        o.inc   = inc;
        o.dec   = dec;
        o.sel   = sel;
        o.disp  = disp;
        o.led   = led;
        o.ring  = ring;
        o.alarm = {3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
        return o;
    endfunction

    // Steady outputs for a state with no adjust pulse.
    function automatic obs_t idle(int s, bit ring);
        obs_t o;
        case (s)
            TH:      o = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, ah, am);
            TM:      o = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, ah, am);
            AH:      o = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, ah, am);
            AM:      o = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, ah, am);
            default: o = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, ring, ah, am);
        endcase
        return o;
    endfunction

    function automatic obs_t pulse(int s, bit up);
        obs_t o;
        o     = idle(s, 1'b0);
        o.inc = up;
        o.dec = !up;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.ce    = counter_enable;
        o.inc   = time_inc;
        o.dec   = time_dec;
        o.sel   = time_sel;
        o.disp  = disp_alarm;
        o.led   = mode_led;
        o.ring  = ringing;
        o.alarm = {a_hour_tens, a_hour_units, a_min_tens, a_min_units};
        return o;
    endfunction

    task automatic drive(logic [4:0] b);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        @(posedge clk);
        #1;
        {btn_c, btn_l, btn_r, btn_u, btn_d} = BN;
    endtask

    task automatic set_time(int h, int m);
        t_hour_tens  = 3'(h / 10);
        t_hour_units = 4'(h % 10);
        t_min_tens   = 3'(m / 10);
        t_min_units  = 4'(m % 10);
    endtask

    task automatic test_reset();
        obs_t got, e;
        reset = 1'b1;
        sb.push_back(idle(SC, 1'b0));
        drive(BN);
        drive(BN);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got, e);
        end
        reset = 1'b0;
        sb.push_back(idle(SC, 1'b0));
        drive(BN);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL after_reset got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_time_adjust();
        logic [4:0] btns[$] = '{BC, BU, BN, BD, BR, BU, BN, BD, BN};
        obs_t got, e;
        sb.push_back(idle(TH, 1'b0));
        sb.push_back(pulse(TH, 1'b1));
        sb.push_back(idle(TH, 1'b0));
        sb.push_back(pulse(TH, 1'b0));
        sb.push_back(idle(TM, 1'b0));
        sb.push_back(pulse(TM, 1'b1));
        sb.push_back(idle(TM, 1'b0));
        sb.push_back(pulse(TM, 1'b0));
        sb.push_back(idle(TM, 1'b0));
        foreach (btns[i]) begin
            drive(btns[i]);
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL time_adjust step %0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [4:0] btns[$] = '{BR, BR, BR, BL, BL, BL, BL, BL | BR, BR | BU, BC, BR, BL, BU, BD};
        int         sts[$]  = '{AH, AM, TH, AM, AH, TM, TH, AM, TH, SC, SC, SC, SC, SC};
        obs_t got, e;
        foreach (btns[i]) begin
            sb.push_back(idle(sts[i], 1'b0));
            drive(btns[i]);
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mode_cycle step %0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_alarm_wrap();
        obs_t got, e;
        drive(BC);
        drive(BR);
        drive(BR);
        for (int i = 0; i < 26; i++) begin
            if (i < 24 || i == 25) ah = (ah + 1) % 24;
            else ah = (ah + 23) % 24;
            sb.push_back(idle(AH, 1'b0));
            drive((i == 24) ? BD : BU);
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL alarm_hour step %0d got=%h exp=%h", i, got, e);
            end
        end
        drive(BR);
        for (int i = 0; i < 64; i++) begin
            logic [4:0] b;
            if (i == 0 || i == 63) begin
                b = BD;
                am = (am + 59) % 60;
            end else if (i == 62) begin
                b = BU | BD;
                am = (am + 1) % 60;
            end else begin
                b = BU;
                am = (am + 1) % 60;
            end
            sb.push_back(idle(AM, 1'b0));
            drive(b);
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL alarm_min step %0d got=%h exp=%h", i, got, e);
            end
        end
        sb.push_back(idle(SC, 1'b0));
        drive(BC);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL alarm_exit got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_priority();
        obs_t got, e;
        drive(BC);
        drive(BR);
        sb.push_back(idle(SC, 1'b0));
        drive(BC | BU);
        sb.push_back(idle(SC, 1'b0));
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL c_beats_u got=%h exp=%h", got, e);
        end
        drive(BN);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL no_late_inc got=%h exp=%h", got, e);
        end
    endtask

    task automatic wait_ring(logic target, string name);
        obs_t got, e;
        int   n = 0;
        sb.push_back(idle(SC, target));
        do begin
            drive(BN);
            n++;
        end while (ringing !== target && n < 4);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cycles=%0d", name, got, e, n);
        end
    endtask

    task automatic quiet_ticks(int cnt, string name);
        obs_t got, e;
        for (int i = 0; i < cnt; i++) begin
            sb.push_back(idle(SC, 1'b0));
            drive(BN);
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s tick %0d got=%h exp=%h", name, i, got, e);
            end
        end
    endtask

    task automatic test_ringing();
        obs_t got, e;
        drive(BC);
        drive(BR);
        drive(BR);
        for (int i = 0; i < 7; i++) drive(BU);
        drive(BR);
        for (int i = 0; i < 30; i++) drive(BU);
        drive(BC);
        ah = 7;
        am = 30;
        set_time(7, 29);
        alarm_en = 1'b1;
        quiet_ticks(1, "armed_no_match");
        set_time(7, 30);
        wait_ring(1'b1, "ring_on_match");
        sb.push_back(idle(SC, 1'b0));
        drive(BU);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL btn_silence got=%h exp=%h", got, e);
        end
        quiet_ticks(3, "no_rering");
        set_time(7, 29);
        quiet_ticks(1, "pre_match");
        set_time(7, 30);
        wait_ring(1'b1, "ring_again");
        set_time(7, 31);
        wait_ring(1'b0, "auto_silence");
        set_time(7, 29);
        quiet_ticks(1, "pre_match2");
        set_time(7, 30);
        wait_ring(1'b1, "ring_third");
        alarm_en = 1'b0;
        wait_ring(1'b0, "disarm_clears");
        alarm_en = 1'b1;
        quiet_ticks(2, "rearm_no_edge");
        drive(BC);
        drive(BC);
        quiet_ticks(2, "reenter_no_ring");
        set_time(7, 29);
        quiet_ticks(1, "pre_match3");
        set_time(7, 30);
        wait_ring(1'b1, "ring_fourth");
        sb.push_back(idle(SC, 1'b0));
        drive(BC);
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL btn_c_consumed got=%h exp=%h", got, e);
        end
        alarm_en = 1'b0;
        set_time(12, 0);
    endtask

    task automatic test_reset_mid_adjust();
        obs_t got, e;
        drive(BC);
        drive(BL);
        reset = 1'b1;
        ah = 0;
        am = 0;
        sb.push_back(idle(SC, 1'b0));
        drive(BU);
        reset = 1'b0;
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_adjust got=%h exp=%h", got, e);
        end
        quiet_ticks(1, "after_mid_reset");
    endtask

    initial begin
        reset    = 1'b1;
        alarm_en = 1'b0;
        {btn_c, btn_l, btn_r, btn_u, btn_d} = BN;
        set_time(12, 0);
        #1;
        test_reset();
        test_time_adjust();
        test_mode_cycle();
        test_alarm_wrap();
        test_priority();
        test_ringing();
        test_reset_mid_adjust();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
